// File: rtl/scanline_tone_sequencer.sv
// Beam-position driven melody sequencer: line/frame strobes from hpos/vpos clock
// an 8-note tone + bass square-wave pair, shaped by a decaying PWM envelope.
module scanline_tone_sequencer #(
    parameter int BASS_OFFSET     = 60,
    parameter int ENV_STEP_FRAMES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] hpos,
    input  logic [9:0] vpos,
    input  logic       enable,
    input  logic [3:0] tempo,
    output logic       sound,
    output logic [2:0] note_idx,
    output logic [3:0] env_level
);

    localparam int ENV_W = (ENV_STEP_FRAMES > 1) ? $clog2(ENV_STEP_FRAMES) : 1;
    localparam logic [ENV_W-1:0] ENV_LAST = ENV_W'(ENV_STEP_FRAMES - 1);

    function automatic logic [7:0] note_half(input logic [2:0] idx);
        case (idx)
            3'd0:    return 8'd120;
            3'd1:    return 8'd107;
            3'd2:    return 8'd95;
            3'd3:    return 8'd113;
            3'd4:    return 8'd95;
            3'd5:    return 8'd107;
            3'd6:    return 8'd120;
            default: return 8'd80;
        endcase
    endfunction

    function automatic logic [3:0] sat_dec(input logic [3:0] v);
        return (v == 4'd0) ? 4'd0 : v - 4'd1;
    endfunction

    logic [3:0]       frame_cnt_q, frame_cnt_d;
    logic [2:0]       note_idx_q, note_idx_d;
    logic [3:0]       env_level_q, env_level_d;
    logic [ENV_W-1:0] env_cnt_q, env_cnt_d;
    logic [7:0]       tone_cnt_q, tone_cnt_d;
    logic [8:0]       bass_cnt_q, bass_cnt_d;
    logic             tone_q, tone_d;
    logic             bass_q, bass_d;
    logic [3:0]       pwm_cnt_q, pwm_cnt_d;
    logic             sound_q, sound_d;

    logic       line_stb, frame_stb, advance;
    logic [7:0] half;
    logic [8:0] bass_half;

    assign line_stb  = (hpos == 10'd0);
    assign frame_stb = line_stb && (vpos == 10'd0);
    assign advance   = enable && frame_stb && (frame_cnt_q >= tempo);
    assign half      = note_half(note_idx_q);
    assign bass_half = {1'b0, half} + 9'(BASS_OFFSET);

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        note_idx_d  = note_idx_q;
        env_level_d = env_level_q;
        env_cnt_d   = env_cnt_q;
        tone_cnt_d  = tone_cnt_q;
        bass_cnt_d  = bass_cnt_q;
        tone_d      = tone_q;
        bass_d      = bass_q;
        pwm_cnt_d   = pwm_cnt_q;

        // A note advance restarts the counters but keeps oscillator levels, and
        // pre-empts any line update that coincides with it.
        if (advance) begin
            frame_cnt_d = 4'd0;
            note_idx_d  = note_idx_q + 3'd1;
            env_level_d = 4'd15;
            env_cnt_d   = '0;
            tone_cnt_d  = 8'd0;
            bass_cnt_d  = 9'd0;
        end else if (enable) begin
            if (frame_stb) begin
                frame_cnt_d = frame_cnt_q + 4'd1;
                if (env_cnt_q == ENV_LAST) begin
                    env_cnt_d   = '0;
                    env_level_d = sat_dec(env_level_q);
                end else begin
                    env_cnt_d = env_cnt_q + 1'b1;
                end
            end
            if (line_stb) begin
                if (tone_cnt_q >= half) begin
                    tone_cnt_d = 8'd0;
                    tone_d     = ~tone_q;
                end else begin
                    tone_cnt_d = tone_cnt_q + 8'd1;
                end
                if (bass_cnt_q >= bass_half) begin
                    bass_cnt_d = 9'd0;
                    bass_d     = ~bass_q;
                end else begin
                    bass_cnt_d = bass_cnt_q + 9'd1;
                end
            end
        end

        if (enable) begin
            pwm_cnt_d = pwm_cnt_q + 4'd1;
        end

        sound_d = enable && (pwm_cnt_q < env_level_q) && (tone_q || bass_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt_q <= 4'd0;
            note_idx_q  <= 3'd0;
            env_level_q <= 4'd15;
            env_cnt_q   <= '0;
            tone_cnt_q  <= 8'd0;
            bass_cnt_q  <= 9'd0;
            tone_q      <= 1'b0;
            bass_q      <= 1'b0;
            pwm_cnt_q   <= 4'd0;
            sound_q     <= 1'b0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            note_idx_q  <= note_idx_d;
            env_level_q <= env_level_d;
            env_cnt_q   <= env_cnt_d;
            tone_cnt_q  <= tone_cnt_d;
            bass_cnt_q  <= bass_cnt_d;
            tone_q      <= tone_d;
            bass_q      <= bass_d;
            pwm_cnt_q   <= pwm_cnt_d;
            sound_q     <= sound_d;
        end
    end

    assign sound     = sound_q;
    assign note_idx  = note_idx_q;
    assign env_level = env_level_q;

endmodule

// File: tb/tb_scanline_tone_sequencer.sv
// Directed bench for scanline_tone_sequencer: synthetic short lines/frames driven
// through hpos/vpos, with hand-derived expectations for sequencing, envelope and audio.
module tb_scanline_tone_sequencer;

    logic       clk = 1'b0;
    logic       reset, enable;
    logic [9:0] hpos, vpos;
    logic [3:0] tempo;
    logic       sound, sound1;
    logic [2:0] note_idx, note_idx1;
    logic [3:0] env_level, env_level1;

    int errors = 0;
    int checks = 0;
    int hi_cnt = 0;
    int hi_cnt1 = 0;

    always #5 clk = ~clk;

    scanline_tone_sequencer dut (
        .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos), .enable(enable),
        .tempo(tempo), .sound(sound), .note_idx(note_idx), .env_level(env_level)
    );

    // Second instance with a one-frame envelope step for the full-decay case.
    scanline_tone_sequencer #(.BASS_OFFSET(60), .ENV_STEP_FRAMES(1)) dut1 (
        .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos), .enable(enable),
        .tempo(tempo), .sound(sound1), .note_idx(note_idx1), .env_level(env_level1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int h, input int v);
        hpos = 10'(h);
        vpos = 10'(v);
        @(posedge clk);
        #1;
        hi_cnt  += sound  ? 1 : 0;
        hi_cnt1 += sound1 ? 1 : 0;
    endtask

    task automatic line(input int v, input int nclk);
        for (int c = 0; c < nclk; c++) step(c, v);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(5, 5);
        reset = 1'b0;
    endtask

    initial begin
        reset  = 1'b1;
        enable = 1'b0;
        tempo  = 4'd0;
        hpos   = 10'd5;
        vpos   = 10'd5;

        // Reset state
        do_reset();
        chk("rst_sound", sound, 0);
        chk("rst_note", note_idx, 0);
        chk("rst_env", env_level, 15);
        chk("rst_env1", env_level1, 15);

        // tempo=0: every frame start advances the note
        enable = 1'b1;
        tempo  = 4'd0;
        for (int f = 0; f < 8; f++) begin
            step(0, 0);
            chk($sformatf("t0_note_f%0d", f + 1), note_idx, (f + 1) % 8);
            chk($sformatf("t0_env_f%0d", f + 1), env_level, 15);
            step(1, 0);
            line(1, 2);
        end

        // tempo=15: one advance per 16 frames, envelope decays every 4 frames
        do_reset();
        tempo = 4'd15;
        for (int k = 1; k <= 16; k++) begin
            step(0, 0);
            chk($sformatf("t15_note_f%0d", k), note_idx, (k == 16) ? 1 : 0);
            chk($sformatf("t15_env_f%0d", k), env_level, (k < 16) ? 15 - k / 4 : 15);
            step(1, 0);
            line(1, 2);
        end
        // Lowering tempo below frame count advances on the next frame
        for (int k = 1; k <= 3; k++) begin
            step(0, 0);
            chk($sformatf("tlow_note_f%0d", k), note_idx, 1);
            line(1, 2);
        end
        tempo = 4'd2;
        step(0, 0);
        chk("tlow_advance", note_idx, 2);
        line(1, 2);

        // Oscillator timing on note 0: 16-clock lines keep PWM phase aligned
        do_reset();
        tempo = 4'd15;
        for (int k = 1; k <= 400; k++) begin
            for (int c = 0; c < 16; c++) begin
                if (k == 122 && c == 0) hi_cnt = 0;
                step(c, k - 1);
                if (c == 8 && (k == 120 || k == 121 || k == 180 || k == 181 ||
                               k == 361 || k == 362 || k == 363))
                    chk($sformatf("osc_sound_l%0d", k), sound,
                        (((k / 121) % 2) == 1 || ((k / 181) % 2) == 1) ? 1 : 0);
                if (c == 8 && (k == 120 || k == 121 || k == 241 || k == 242))
                    chk($sformatf("osc_tone_l%0d", k), dut.tone_q, (k / 121) % 2);
                if (c == 8 && (k == 180 || k == 181 || k == 361 || k == 362))
                    chk($sformatf("osc_bass_l%0d", k), dut.bass_q, (k / 181) % 2);
            end
            if (k == 122) chk("osc_duty_l122", hi_cnt, 15);
        end

        // Full envelope decay (one-frame step) then duty restore at the advance
        do_reset();
        tempo = 4'd15;
        for (int f = 1; f <= 16; f++) begin
            for (int l = 0; l < 10; l++) begin
                for (int c = 0; c < 16; c++) begin
                    if (f == 15 && l == 0 && c == 1) hi_cnt1 = 0;
                    if (f == 16 && l == 1 && c == 0) hi_cnt1 = 0;
                    step(c, l);
                    if (f == 15 && l == 0 && c == 0) chk("dec_env_f15", env_level1, 0);
                    if (f == 16 && l == 0 && c == 0) begin
                        chk("dec_note_f16", note_idx1, 1);
                        chk("dec_env_f16", env_level1, 15);
                        chk("dec_frame_silent", hi_cnt1, 0);
                    end
                end
                if (f == 16 && l == 1) chk("dec_duty_after_adv", hi_cnt1, 15);
            end
        end

        // Enable gap mid-note: state freezes, tone resumes with same remaining count
        do_reset();
        tempo = 4'd15;
        for (int v = 0; v < 130; v++) line(v, 16);
        for (int c = 0; c < 5; c++) step(c, 130);
        chk("en_sound_before", sound, 1);
        enable = 1'b0;
        step(5, 130);
        chk("en_sound_off", sound, 0);
        for (int c = 6; c < 16; c++) step(c, 130);
        for (int f = 0; f < 3; f++)
            for (int v = 0; v < 3; v++) line(v, 16);
        chk("en_sound_held0", sound, 0);
        chk("en_note_held", note_idx, 0);
        chk("en_env_held", env_level, 15);
        chk("en_env1_held", env_level1, 14);
        chk("en_tone_held", dut.tone_q, 1);
        enable = 1'b1;
        for (int v = 131; v < 241; v++) line(v, 16);
        chk("en_tone_before_toggle", dut.tone_q, 1);
        line(241, 16);
        chk("en_tone_toggle", dut.tone_q, 0);

        // Reset mid-frame with note 5; the strobe in the reset cycle is ignored
        do_reset();
        tempo = 4'd0;
        for (int f = 0; f < 5; f++) begin
            line(0, 4);
            line(1, 4);
        end
        chk("mr_note_before", note_idx, 5);
        reset = 1'b1;
        step(0, 0);
        reset = 1'b0;
        chk("mr_note", note_idx, 0);
        chk("mr_env", env_level, 15);
        chk("mr_sound", sound, 0);
        step(1, 0);
        line(1, 4);
        step(0, 0);
        chk("mr_resume_note", note_idx, 1);
        chk("mr_resume_env", env_level, 15);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
